// File: rtl/microwave_controller_pkg.sv
// Shared types and constants for the microwave cook-time controller.
package microwave_controller_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCooking,
    StPaused,
    StDone
  } state_e;

  // Cook time m:ss held as three BCD digits.
  typedef struct packed {
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } cook_time_t;

  localparam bcd_t MAX_DIGIT    = 4'd9;
  localparam bcd_t MAX_SEC_TENS = 4'd5;

  localparam cook_time_t TIME_ZERO = '{min_ones: 4'd0, sec_tens: 4'd0, sec_ones: 4'd0};
  localparam cook_time_t TIME_ONE  = '{min_ones: 4'd0, sec_tens: 4'd0, sec_ones: 4'd1};

  // One-second BCD decrement; callers never pass 0:00.
  function automatic cook_time_t dec_time(input cook_time_t t);
    cook_time_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.sec_ones = MAX_DIGIT;
      if (t.sec_tens != 4'd0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = MAX_SEC_TENS;
        r.min_ones = t.min_ones - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/microwave_controller_sync_edge.sv
// Two-flop synchronizer followed by a registered single-cycle edge detector.
// Rise = 1 detects a rising edge (idle level 0); Rise = 0 detects a falling
// edge (idle level 1). The pulse appears one cycle after the synchronized
// level changes, so a consumer acts on the 4th clock edge after the input.
module microwave_controller_sync_edge #(
  parameter bit Rise = 1'b1
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic din_i,
  output logic level_o,
  output logic pulse_o
);

  localparam bit IdleLevel = ~Rise;

  logic s1_q, s2_q, hist_q, pulse_q;

  // Synchronizer chain, edge history and registered edge pulse.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      s1_q    <= IdleLevel;
      s2_q    <= IdleLevel;
      hist_q  <= IdleLevel;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= din_i;
      s2_q    <= s1_q;
      hist_q  <= s2_q;
      pulse_q <= Rise ? (s2_q & ~hist_q) : (~s2_q & hist_q);
    end
  end

  assign level_o = hist_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/microwave_controller.sv
// Microwave sequencing controller: keypad digit entry into an m:ss BCD
// register, cook/pause/done FSM and 1 Hz countdown.
module microwave_controller
  import microwave_controller_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       magnetron_on,
  output logic       done
);

  logic key, tick, start, stop, door_ok;
  logic load_lvl, tick_lvl, start_lvl, stop_lvl, door_pulse;

  microwave_controller_sync_edge #(.Rise(1'b0)) u_sync_load (
    .clk_i(clk), .clear_i(clear), .din_i(loadn), .level_o(load_lvl), .pulse_o(key)
  );
  microwave_controller_sync_edge #(.Rise(1'b1)) u_sync_tick (
    .clk_i(clk), .clear_i(clear), .din_i(pgt_1hz), .level_o(tick_lvl), .pulse_o(tick)
  );
  microwave_controller_sync_edge #(.Rise(1'b0)) u_sync_start (
    .clk_i(clk), .clear_i(clear), .din_i(startn), .level_o(start_lvl), .pulse_o(start)
  );
  microwave_controller_sync_edge #(.Rise(1'b0)) u_sync_stop (
    .clk_i(clk), .clear_i(clear), .din_i(stopn), .level_o(stop_lvl), .pulse_o(stop)
  );
  microwave_controller_sync_edge #(.Rise(1'b1)) u_sync_door (
    .clk_i(clk), .clear_i(clear), .din_i(door_closed), .level_o(door_ok), .pulse_o(door_pulse)
  );

  // Only the door is consumed as a level; the other levels and the door edge are spare.
  logic unused_sync;
  assign unused_sync = ^{load_lvl, tick_lvl, start_lvl, stop_lvl, door_pulse};

  state_e     state_q, state_d;
  cook_time_t ct_q, ct_d;

  logic       digit_ok, shift_ok, time_zero;
  cook_time_t shifted, fresh;

  // Candidate digit-shift results, from the live register and from a zeroed one.
  always_comb begin
    digit_ok  = key && (D <= MAX_DIGIT);
    shift_ok  = digit_ok && (ct_q.sec_ones <= MAX_SEC_TENS);
    time_zero = (ct_q == TIME_ZERO);
    shifted   = '{min_ones: ct_q.sec_tens, sec_tens: ct_q.sec_ones, sec_ones: D};
    fresh     = '{min_ones: 4'd0, sec_tens: 4'd0, sec_ones: D};
  end

  // Next state and next cook time; stop > door open > tick > start > key.
  always_comb begin
    state_d = state_q;
    ct_d    = ct_q;
    unique case (state_q)
      StIdle: begin
        if (!stop && shift_ok) begin
          ct_d    = shifted;
          state_d = StEntry;
        end
      end
      StEntry: begin
        if (stop) begin
          ct_d    = TIME_ZERO;
          state_d = StIdle;
        end else if (start && door_ok && !time_zero) begin
          state_d = StCooking;
        end else if (shift_ok) begin
          ct_d = shifted;
        end
      end
      StCooking: begin
        if (stop || !door_ok) begin
          state_d = StPaused;
        end else if (tick && !time_zero) begin
          ct_d = dec_time(ct_q);
          if (ct_q == TIME_ONE) state_d = StDone;
        end
      end
      StPaused: begin
        if (stop) begin
          ct_d    = TIME_ZERO;
          state_d = StIdle;
        end else if (start && door_ok) begin
          state_d = StCooking;
        end
      end
      StDone: begin
        if (stop) begin
          ct_d    = TIME_ZERO;
          state_d = StIdle;
        end else if (digit_ok) begin
          // Old digits are discarded, so the sec_ones guard cannot reject here.
          ct_d    = fresh;
          state_d = StEntry;
        end
      end
      default: begin
        ct_d    = TIME_ZERO;
        state_d = StIdle;
      end
    endcase
  end

  // State and cook-time registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      ct_q    <= TIME_ZERO;
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
    end
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    min_ones     = ct_q.min_ones;
    sec_tens     = ct_q.sec_tens;
    sec_ones     = ct_q.sec_ones;
    magnetron_on = (state_q == StCooking);
    done         = (state_q == StDone);
  end

endmodule

// File: doc/microwave_controller.md
# microwave_controller

Sequencing controller that sits downstream of the keypad encoder and consumes its digit code, active-low load strobe and 1 Hz tick. Shifts entered digits into a three-digit BCD cook-time register (m:ss, 0:00–9:59), runs the cook/pause/done state machine from the start, stop and door inputs, and counts the time down once per tick. Drives the magnetron enable, the time digits for the display path, and a done flag.

## Interface
- No parameters. Limits are fixed constants: max minutes 9, max seconds-tens 5.
- clk  in  1  system clock; the same clock that feeds the encoder.
- clear  in  1  reset, asynchronous, active-high.
- D  in  4  digit code from the encoder. Codes 0–9 are valid; 10–15 are ignored.
- loadn  in  1  active-low digit strobe from the encoder; low while a key is held.
- pgt_1hz  in  1  1 Hz tick from the encoder; a rising edge means one second.
- startn  in  1  start button, active-low.
- stopn  in  1  stop/cancel button, active-low.
- door_closed  in  1  1 = door closed.
- min_ones  out  4  BCD minutes.
- sec_tens  out  4  BCD seconds tens.
- sec_ones  out  4  BCD seconds ones.
- magnetron_on  out  1  high only in COOKING.
- done  out  1  high only in DONE.

## Operation
- Input conditioning:
  - loadn, pgt_1hz, startn, stopn and door_closed each pass through a 2-flop synchronizer.
  - Events are single-cycle pulses: key = loadn fall, tick = pgt_1hz rise, start = startn fall, stop = stopn fall.
  - D is sampled on the key pulse cycle.
- States: IDLE, ENTRY, COOKING, PAUSED, DONE.
- Reset values: state IDLE; all digits 0; magnetron_on 0; done 0; edge-detect history = inactive levels.
- Digit shift, on a key pulse with D ≤ 9, in IDLE, ENTRY or DONE:
  - min_ones ← sec_tens, sec_tens ← sec_ones, sec_ones ← D.
  - The key is rejected with no change if the old sec_ones > 5, because sec_tens would become invalid.
  - If the state is DONE, all digits are zeroed first, then D is shifted in.
  - Next state is ENTRY.
- Key pulses in COOKING or PAUSED are ignored.
- Transitions:
  - ENTRY + start + door_closed + time ≠ 0:00 → COOKING. Start with the door open or with zero time is ignored.
  - ENTRY + stop → IDLE, digits cleared.
  - COOKING + stop → PAUSED.
  - COOKING + door opened (synchronized door_closed = 0) → PAUSED.
  - COOKING + tick → decrement; reaching 0:00 → DONE.
  - PAUSED + start + door_closed → COOKING.
  - PAUSED + stop → IDLE, digits cleared.
  - DONE + stop → IDLE, digits cleared. DONE + key → ENTRY, as described above.
- BCD decrement, per tick:
  - sec_ones 0 → 9 with a borrow into sec_tens.
  - sec_tens 0 → 5 with a borrow into min_ones.
  - Decrement is never applied at 0:00.
- Priority for simultaneous events:
  - stop > door open > tick > start > key.
  - In COOKING, stop or door-open together with a tick means no decrement.
  - Start and stop together means stop wins.
- clear asserted mid-cook returns everything to reset values immediately.

## Timing
- Input-to-action latency: 2 synchronizer flops + 1 edge register. The state or digit update becomes visible at the 4th rising clk edge after the raw input changes, provided setup is met.
- magnetron_on and done are registered Moore outputs, driven from the state register only.
- The 0:01 → 0:00 tick and entry into DONE occur on the same edge; done rises on that edge.
- One decrement at most per tick pulse. A tick held high longer does not repeat.
- A held key produces exactly one shift. A second shift requires loadn to return high and then fall again.

## Structure
- Shared package: state enum (IDLE, ENTRY, COOKING, PAUSED, DONE), constant MAX_SEC_TENS = 5, BCD digit type (4 bits).
- Sub-module sync_edge, instantiated 5×. Contains a 2-flop synchronizer plus an edge detector, with a parameter selecting rise/fall and outputs for the synchronized level and the pulse.
- The top level holds the FSM, the digit register and the BCD decrement logic.

## Test plan
- Entry: keys 1, 3, 0 → display 1:30, state ENTRY. Key 7 then key 9 from cleared → 0:79 rejected; the second key leaves 0:07.
- Cook to done: set 0:03, door closed, start → magnetron_on = 1; after 3 ticks → 0:00, done = 1, magnetron_on = 0. Fourth tick → no change.
- Borrow: 1:00, one tick → 0:59; 0:10, one tick → 0:09.
- Pause/resume: cooking at 0:20, door opens → PAUSED, magnetron_on = 0, ticks ignored. Door closes + start → resumes from 0:20. Stop in PAUSED → IDLE, 0:00.
- Guards: start at 0:00 or with door open → stays ENTRY. Stop coincident with tick in COOKING → PAUSED, no decrement.
- Async clear asserted during COOKING at 0:45 → immediate IDLE, 0:00, magnetron_on = 0, done = 0.
